// File: rtl/regfile_wport_arbiter.sv
// regfile_wport_arbiter
//   Shares the single write port of a 1r1w register file between two
//   requesters. After reset it first sweeps p_init_value into every entry
//   (INIT), then arbitrates the two valid/ready ports (RUN). When both ports
//   are valid, the grant alternates between them.
//
// Ports
//   clk, reset            clock; synchronous active-high reset
//   req{0,1}_val/_rdy     write request handshake (rdy = grant, combinational)
//   req{0,1}_addr/_data   write target entry / data
//   rf_wen/_waddr/_wdata  register file write port, unregistered
//   init_done             high once the initialization sweep has completed

// One requester lane. It raises its grant when RUN is active, it is valid,
// and the other lane is idle or this lane holds priority. The lane's
// addr/data are masked by the grant, so the write-port mux is a plain OR
// across the lanes.
module regfile_wport_lane #(
  parameter int p_addr_nbits = 5,
  parameter int p_data_nbits = 32
) (
  input  logic                    run,
  input  logic                    val,
  input  logic                    oth_val,
  input  logic                    favoured,
  input  logic [p_addr_nbits-1:0] addr,
  input  logic [p_data_nbits-1:0] data,
  output logic                    gnt,
  output logic [p_addr_nbits-1:0] addr_m,
  output logic [p_data_nbits-1:0] data_m
);
  assign gnt    = run & val & (~oth_val | favoured);
  assign addr_m = {p_addr_nbits{gnt}} & addr;
  assign data_m = {p_data_nbits{gnt}} & data;
endmodule

module regfile_wport_arbiter #(
  parameter  int                      p_data_nbits  = 32,
  parameter  int                      p_num_entries = 32,
  parameter  logic [p_data_nbits-1:0] p_init_value  = '0,
  localparam int                      c_addr_nbits  = $clog2(p_num_entries)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    req0_val,
  output logic                    req0_rdy,
  input  logic [c_addr_nbits-1:0] req0_addr,
  input  logic [p_data_nbits-1:0] req0_data,
  input  logic                    req1_val,
  output logic                    req1_rdy,
  input  logic [c_addr_nbits-1:0] req1_addr,
  input  logic [p_data_nbits-1:0] req1_data,
  output logic                    rf_wen,
  output logic [c_addr_nbits-1:0] rf_waddr,
  output logic [p_data_nbits-1:0] rf_wdata,
  output logic                    init_done
);
  localparam int NUM_LANES = 2;
  localparam logic [c_addr_nbits-1:0] c_last = c_addr_nbits'(p_num_entries - 1);

  if (p_num_entries < 2) begin : g_bad_size
    $error("regfile_wport_arbiter: p_num_entries must be at least 2");
  end

  typedef struct packed {
    logic                    val;
    logic [c_addr_nbits-1:0] addr;
    logic [p_data_nbits-1:0] data;
  } wreq_t;

  typedef enum logic {S_INIT, S_RUN} state_t;

  state_t                    state, state_next;
  logic [c_addr_nbits-1:0]   cnt, cnt_next;
  logic                      prio, prio_next;
  logic                      run;

  wreq_t [NUM_LANES-1:0]                   req;
  logic  [NUM_LANES-1:0]                   gnt;
  logic  [NUM_LANES-1:0]                   favoured;
  logic  [NUM_LANES-1:0][c_addr_nbits-1:0] addr_m;
  logic  [NUM_LANES-1:0][p_data_nbits-1:0] data_m;

  assign req[0] = '{val: req0_val, addr: req0_addr, data: req0_data};
  assign req[1] = '{val: req1_val, addr: req1_addr, data: req1_data};

  // prio names the favoured port; lane 0 is favoured when prio == 0.
  assign favoured = {prio, ~prio};

  // Reset masks every grant combinationally so rdy/wen drop in the same
  // cycle reset rises, whatever state the register holds.
  assign run = (state == S_RUN) & ~reset;

  for (genvar n = 0; n < NUM_LANES; n++) begin : g_lane
    regfile_wport_lane #(
      .p_addr_nbits (c_addr_nbits),
      .p_data_nbits (p_data_nbits)
    ) u_lane (
      .run      (run),
      .val      (req[n].val),
      .oth_val  (req[NUM_LANES-1-n].val),
      .favoured (favoured[n]),
      .addr     (req[n].addr),
      .data     (req[n].data),
      .gnt      (gnt[n]),
      .addr_m   (addr_m[n]),
      .data_m   (data_m[n])
    );
  end

  assign req0_rdy = gnt[0];
  assign req1_rdy = gnt[1];

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    prio_next  = prio;
    rf_wen     = 1'b0;
    rf_waddr   = '0;
    rf_wdata   = '0;
    init_done  = 1'b0;
    if (!reset) begin
      case (state)
        S_INIT: begin
          rf_wen   = 1'b1;
          rf_waddr = cnt;
          rf_wdata = p_init_value;
          // Leave on the last entry and park the counter there, so it
          // never wraps past p_num_entries-1 for non-power-of-two sizes.
          if (cnt == c_last) state_next = S_RUN;
          else               cnt_next   = cnt + 1'b1;
        end
        S_RUN: begin
          init_done = 1'b1;
          rf_wen    = |gnt;
          rf_waddr  = addr_m[0] | addr_m[1];
          rf_wdata  = data_m[0] | data_m[1];
          // Hand priority to the port that did not just write.
          if      (gnt[0]) prio_next = 1'b1;
          else if (gnt[1]) prio_next = 1'b0;
        end
        default: state_next = S_INIT;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_INIT;
      cnt   <= '0;
      prio  <= 1'b0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      prio  <= prio_next;
    end
  end
endmodule

// File: tb/tb_regfile_wport_arbiter.sv
// Directed bench for regfile_wport_arbiter (4 entries x 8 bits, init A5).
// A 4-entry array captures the write port; after each scenario its
// contents are compared with hand-computed expectations.
module tb_regfile_wport_arbiter;
  logic       clk = 1'b0;
  logic       reset;
  logic       req0_val, req1_val;
  logic       req0_rdy, req1_rdy;
  logic [1:0] req0_addr, req1_addr;
  logic [7:0] req0_data, req1_data;
  logic       rf_wen;
  logic [1:0] rf_waddr;
  logic [7:0] rf_wdata;
  logic       init_done;

  int total = 0;
  int bad   = 0;

  logic [7:0] rf [4];

  always #5 clk = ~clk;

  regfile_wport_arbiter #(
    .p_data_nbits  (8),
    .p_num_entries (4),
    .p_init_value  (8'hA5)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req0_val  (req0_val),
    .req0_rdy  (req0_rdy),
    .req0_addr (req0_addr),
    .req0_data (req0_data),
    .req1_val  (req1_val),
    .req1_rdy  (req1_rdy),
    .req1_addr (req1_addr),
    .req1_data (req1_data),
    .rf_wen    (rf_wen),
    .rf_waddr  (rf_waddr),
    .rf_wdata  (rf_wdata),
    .init_done (init_done)
  );

  always @(posedge clk) if (rf_wen) rf[rf_waddr] <= rf_wdata;

  // Out-of-range addresses are illegal for a 4-entry file; with a 2-bit
  // address they cannot be driven here, but the flag stays in place.
  always @(posedge clk)
    if ((req0_val && req0_addr > 2'd3) || (req1_val && req1_addr > 2'd3))
      $display("illegal request address observed at %0t", $time);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs change 2 time units after the rising edge; outputs are checked
  // 1 unit later, well clear of both edges.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic drive(input logic v0, input logic [1:0] a0, input logic [7:0] d0,
                       input logic v1, input logic [1:0] a1, input logic [7:0] d1);
    req0_val = v0; req0_addr = a0; req0_data = d0;
    req1_val = v1; req1_addr = a1; req1_data = d1;
    #1;
  endtask

  task automatic chk_out(input string tag, input logic wen, input logic [1:0] wa,
                         input logic [7:0] wd, input logic r0, input logic r1,
                         input logic done);
    chk({tag, ".wen"},   rf_wen,    wen);
    chk({tag, ".waddr"}, rf_waddr,  wa);
    chk({tag, ".wdata"}, rf_wdata,  wd);
    chk({tag, ".rdy0"},  req0_rdy,  r0);
    chk({tag, ".rdy1"},  req1_rdy,  r1);
    chk({tag, ".done"},  init_done, done);
  endtask

  task automatic chk_rf(input string tag, input logic [7:0] e0, input logic [7:0] e1,
                        input logic [7:0] e2, input logic [7:0] e3);
    chk({tag, ".rf0"}, rf[0], e0);
    chk({tag, ".rf1"}, rf[1], e1);
    chk({tag, ".rf2"}, rf[2], e2);
    chk({tag, ".rf3"}, rf[3], e3);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, ".wen"},  rf_wen,    1'b0);
    chk({tag, ".rdy0"}, req0_rdy,  1'b0);
    chk({tag, ".rdy1"}, req1_rdy,  1'b0);
    chk({tag, ".done"}, init_done, 1'b0);
  endtask

  initial begin
    reset = 1'b1;
    for (int i = 0; i < 4; i++) rf[i] = 8'h00;
    drive(1'b1, 2'd1, 8'hEE, 1'b1, 2'd2, 8'hDD);

    // Two reset cycles with both requests raised: everything held off.
    tick(); #1; chk_reset("rst_c1");
    tick(); reset = 1'b0;

    // Sweep: four cycles of A5 into entries 0..3, requests ignored.
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 2'd3, 8'h77, 1'b1, 2'd0, 8'h66);
      chk_out($sformatf("sweep%0d", i), 1'b1, 2'(i), 8'hA5, 1'b0, 1'b0, 1'b0);
      tick();
    end

    // Fifth cycle: RUN, idle port drives zeros.
    drive(1'b0, 2'd3, 8'h77, 1'b0, 2'd0, 8'h66);
    chk_out("run_idle", 1'b0, 2'd0, 8'h00, 1'b0, 1'b0, 1'b1);
    chk_rf("after_init", 8'hA5, 8'hA5, 8'hA5, 8'hA5);
    tick();

    // Port 0 alone.
    drive(1'b1, 2'd2, 8'h11, 1'b0, 2'd0, 8'h00);
    chk_out("p0_only", 1'b1, 2'd2, 8'h11, 1'b1, 1'b0, 1'b1);
    tick();

    // Port 1 alone (prio was 1): same write again, hands priority back to 0.
    drive(1'b0, 2'd0, 8'h00, 1'b1, 2'd2, 8'h11);
    chk_out("p1_only", 1'b1, 2'd2, 8'h11, 1'b0, 1'b1, 1'b1);
    tick();

    // Both ports hit entry 1 for four cycles from prio 0: grants 0,1,0,1.
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 2'd1, 8'h22, 1'b1, 2'd1, 8'h33);
      if (i % 2 == 0)
        chk_out($sformatf("both%0d", i), 1'b1, 2'd1, 8'h22, 1'b1, 1'b0, 1'b1);
      else
        chk_out($sformatf("both%0d", i), 1'b1, 2'd1, 8'h33, 1'b0, 1'b1, 1'b1);
      tick();
    end
    chk_rf("after_both", 8'hA5, 8'h33, 8'h11, 8'hA5);

    // Three idle cycles: no writes, prio stays with port 0.
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 2'd3, 8'h99, 1'b0, 2'd2, 8'h88);
      chk_out($sformatf("idle%0d", i), 1'b0, 2'd0, 8'h00, 1'b0, 1'b0, 1'b1);
      tick();
    end
    drive(1'b1, 2'd3, 8'h44, 1'b1, 2'd0, 8'h55);
    chk_out("post_idle0", 1'b1, 2'd3, 8'h44, 1'b1, 1'b0, 1'b1);
    tick();
    drive(1'b1, 2'd3, 8'h44, 1'b1, 2'd0, 8'h55);
    chk_out("post_idle1", 1'b1, 2'd0, 8'h55, 1'b0, 1'b1, 1'b1);
    tick();
    // Port 1 alone while port 0 holds priority still wins.
    drive(1'b0, 2'd3, 8'h44, 1'b1, 2'd0, 8'h66);
    chk_out("p1_vs_prio", 1'b1, 2'd0, 8'h66, 1'b0, 1'b1, 1'b1);
    tick();
    drive(1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 8'h00);
    chk_rf("after_idle", 8'h66, 8'h33, 8'h11, 8'h44);

    // Reset in RUN with both requests up.
    reset = 1'b1;
    drive(1'b1, 2'd1, 8'hBB, 1'b1, 2'd2, 8'hCC);
    chk_reset("rst_run");
    tick(); reset = 1'b0;
    drive(1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 8'h00);
    chk_rf("after_rst_run", 8'h66, 8'h33, 8'h11, 8'h44);

    // Partial sweep to counter 2, then a one-cycle reset.
    for (int i = 0; i < 2; i++) begin
      #1;
      chk_out($sformatf("psweep%0d", i), 1'b1, 2'(i), 8'hA5, 1'b0, 1'b0, 1'b0);
      tick();
    end
    #1;
    chk_out("psweep2", 1'b1, 2'd2, 8'hA5, 1'b0, 1'b0, 1'b0);
    reset = 1'b1;
    #1;
    chk_reset("rst_sweep");
    tick(); reset = 1'b0;

    // Restart from entry 0, four full cycles, init_done low throughout.
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 2'd1, 8'h12, 1'b0, 2'd0, 8'h00);
      chk_out($sformatf("resweep%0d", i), 1'b1, 2'(i), 8'hA5, 1'b0, 1'b0, 1'b0);
      tick();
    end
    drive(1'b1, 2'd1, 8'h12, 1'b0, 2'd0, 8'h00);
    chk_out("rerun", 1'b1, 2'd1, 8'h12, 1'b1, 1'b0, 1'b1);
    tick();
    drive(1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 8'h00);
    chk_rf("after_resweep", 8'hA5, 8'h12, 8'hA5, 8'hA5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/regfile_wport_arbiter.md
REGFILE_WPORT_ARBITER -- requirements
Module: regfile_wport_arbiter

Interface
REQ-001 Parameter p_data_nbits, default 32, width of each register entry in bits.
REQ-002 Parameter p_num_entries, default 32, number of register file entries; it SHALL be at least 2.
REQ-003 Parameter p_init_value, default 0, value written to every entry by the initialization sweep.
REQ-004 Local constant c_addr_nbits = $clog2(p_num_entries), not to be overridden.
REQ-005 clk  input  1  clock; all state updates occur on its rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 req0_val  input  1  port 0 write request valid.
REQ-008 req0_rdy  output  1  port 0 write request accepted this cycle.
REQ-009 req0_addr  input  c_addr_nbits  port 0 target entry.
REQ-010 req0_data  input  p_data_nbits  port 0 write data.
REQ-011 req1_val, req1_rdy, req1_addr, req1_data  same as port 0, for port 1.
REQ-012 rf_wen  output  1  write enable to the 1r1w register file write port.
REQ-013 rf_waddr  output  c_addr_nbits  register file write address.
REQ-014 rf_wdata  output  p_data_nbits  register file write data.
REQ-015 init_done  output  1  high once the initialization sweep has completed.

Function
REQ-016 The block SHALL implement two states: INIT (sweep) and RUN (arbitrate).
REQ-017 The block SHALL hold an init counter of c_addr_nbits bits and a 1-bit priority register (prio: 0 = port 0 favoured).
REQ-018 INIT: rf_wen=1, rf_waddr=counter, rf_wdata=p_init_value, req0_rdy=req1_rdy=0, init_done=0; the counter SHALL increment by 1 each cycle.
REQ-019 INIT->RUN SHALL occur on the edge where counter==p_num_entries-1, so the sweep occupies exactly p_num_entries cycles; the counter SHALL never exceed p_num_entries-1, including for non-power-of-two sizes.
REQ-020 RUN: init_done=1; the counter SHALL hold its value.
REQ-021 RUN grant rule: if only reqN_val=1, grant port N; if both are valid, grant port prio; if neither is valid, grant none.
REQ-022 reqN_rdy SHALL equal the grant for port N. It SHALL be combinational from state, prio and both valids, and SHALL not depend on reqN_addr or reqN_data.
REQ-023 A transfer on port N occurs when reqN_val && reqN_rdy. In that cycle rf_wen=1 and rf_waddr/rf_wdata equal port N's addr/data, with no pipeline register. The register file captures the write at the edge that ends the cycle.
REQ-024 At most one port SHALL be granted per cycle, even when both ports target the same address.
REQ-025 With no transfer in RUN: rf_wen=0, and rf_waddr/rf_wdata SHALL be driven to 0.
REQ-026 After a transfer on port N, prio SHALL become the other port (1-N) at the next edge; with no transfer, prio SHALL hold.
REQ-027 A requester not granted SHALL see rdy=0 and may keep val asserted; the block SHALL impose no ordering requirement on a stalled requester.
REQ-028 reqN_addr >= p_num_entries on a valid request is illegal. The block SHALL pass such a request through unchanged, and the bench SHALL flag it.

Reset
REQ-029 While reset=1: state=INIT, counter=0, prio=0 at the next edge.
REQ-030 While reset=1: rf_wen=0, req0_rdy=req1_rdy=0, init_done=0. This SHALL hold regardless of state.
REQ-031 Reset asserted mid-sweep or mid-RUN SHALL abandon current activity. The block SHALL restart the full sweep from entry 0 in the first cycle after reset deasserts.

Verification
REQ-032 p_num_entries=4, p_data_nbits=8, p_init_value=8'hA5, reset high 2 cycles then low -> rf_wen=1 with waddr 0,1,2,3 over 4 consecutive cycles, wdata=A5 each cycle; init_done=1 from the 5th cycle; all rdy=0 during the sweep.
REQ-033 After init, port 0 alone presents addr 2, data 8'h11 -> req0_rdy=1, rf_wen=1, waddr=2, wdata=11 in the same cycle; prio becomes 1.
REQ-034 Both ports valid for 4 cycles (port 0: addr 1, data 8'h22; port 1: addr 1, data 8'h33), starting from prio=0 -> grants 0,1,0,1 in those cycles, with one write per cycle and never both rdy high.
REQ-035 No requests for 3 cycles after a port 1 grant -> rf_wen=0, and the next simultaneous request is granted to port 0.
REQ-036 Reset asserted for 1 cycle when the counter is 2 -> the sweep restarts at waddr 0 the cycle after reset and takes 4 full cycles; init_done stays 0 until it completes.
REQ-037 The bench SHALL model the register file as a 4-entry array and check every entry after each scenario. Expected contents after REQ-034 are entry 1=8'h33, entry 2=8'h11, others 8'hA5.
